// File: rtl/ram_pair_loader_pkg.sv
// Shared types and sizing for the dual-RAM loader/verifier path.
package lab4_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 512;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DRAIN,
    S_REPORT
  } state_e;

  function automatic logic [DATA_W-1:0] xor_fold2(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/ram_pair_loader.sv
// Fills RAM0/RAM1 from a 16-bit valid/ready stream, reads both back and
// compares XOR checksums of the readback against the accepted stream.
module ram_pair_loader
  import lab4_pkg::*;
(
  input  logic                   CLOCK_50_I,
  input  logic                   RESET_I,
  input  logic                   start,
  input  logic [2*DATA_W-1:0]    in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ADDR_W-1:0]      write_address,
  output logic [1:0][DATA_W-1:0] write_data,
  output logic [1:0]             write_enable,
  output logic [ADDR_W-1:0]      read_address,
  input  logic [1:0][DATA_W-1:0] read_data,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [DATA_W-1:0]      checksum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        count_q, count_d;
  logic [DATA_W-1:0]        wsum_q, wsum_d;
  logic [DATA_W-1:0]        rsum_q, rsum_d;
  logic [1:0]               vld_q, vld_d;
  logic                     in_ready_q, in_ready_d;
  logic [ADDR_W-1:0]        wa_q, wa_d;
  logic [1:0][DATA_W-1:0]   wd_q, wd_d;
  logic [1:0]               we_q, we_d;
  logic [ADDR_W-1:0]        ra_q, ra_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;
  logic [DATA_W-1:0]        ck_q, ck_d;
  logic                     accept;

  assign accept = (state_q == S_LOAD) && in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wsum_d     = wsum_q;
    rsum_d     = rsum_q;
    in_ready_d = in_ready_q;
    wa_d       = wa_q;
    wd_d       = wd_q;
    we_d       = '0;
    ra_d       = ra_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    ck_d       = ck_q;
    // vld_q[0]: a read address is in flight; vld_q[1]: its data is on read_data now
    vld_d      = {vld_q[0], 1'b0};
    if (vld_q[1]) begin
      rsum_d = rsum_q ^ xor_fold2(read_data[0], read_data[1]);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          count_d    = '0;
          wsum_d     = '0;
          rsum_d     = '0;
          pass_d     = 1'b0;
          in_ready_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (accept) begin
          wa_d    = count_q;
          wd_d[0] = in_data[DATA_W-1:0];
          wd_d[1] = in_data[2*DATA_W-1:DATA_W];
          we_d    = '1;
          wsum_d  = wsum_q ^ xor_fold2(in_data[2*DATA_W-1:DATA_W], in_data[DATA_W-1:0]);
          count_d = count_q + ADDR_W'(1);
          if (count_q == LAST_ADDR) begin
            in_ready_d = 1'b0;
            ra_d       = '0;
            vld_d[0]   = 1'b1;
            state_d    = S_VERIFY;
          end
        end
      end
      S_VERIFY: begin
        // Address DEPTH-1 is the last one issued; hold it rather than wrap.
        if (ra_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          ra_d     = ra_q + ADDR_W'(1);
          vld_d[0] = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!vld_q[0]) begin
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        done_d  = 1'b1;
        pass_d  = (rsum_q == wsum_q);
        ck_d    = wsum_q;
        ra_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
    if (RESET_I) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      wsum_q     <= '0;
      rsum_q     <= '0;
      vld_q      <= '0;
      in_ready_q <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      we_q       <= '0;
      ra_q       <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      ck_q       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wsum_q     <= wsum_d;
      rsum_q     <= rsum_d;
      vld_q      <= vld_d;
      in_ready_q <= in_ready_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      we_q       <= we_d;
      ra_q       <= ra_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      ck_q       <= ck_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign write_address = wa_q;
  assign write_data    = wd_q;
  assign write_enable  = we_q;
  assign read_address  = ra_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign pass          = pass_q;
  assign checksum      = ck_q;

endmodule

// File: tb/tb_ram_pair_loader.sv
// Directed bench for ram_pair_loader with a behavioural pair of 512x8 RAMs.
module tb_ram_pair_loader;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [15:0]     in_data;
  logic            in_valid;
  logic            in_ready;
  logic [8:0]      write_address;
  logic [1:0][7:0] write_data;
  logic [1:0]      write_enable;
  logic [8:0]      read_address;
  logic [1:0][7:0] read_data;
  logic            busy, done, pass;
  logic [7:0]      checksum;

  always #10 clk = ~clk;

  ram_pair_loader dut (
    .CLOCK_50_I    (clk),
    .RESET_I       (rst),
    .start         (start),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .write_address (write_address),
    .write_data    (write_data),
    .write_enable  (write_enable),
    .read_address  (read_address),
    .read_data     (read_data),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .checksum      (checksum)
  );

  logic [7:0]  mem0 [512];
  logic [7:0]  mem1 [512];
  logic        corrupt_req = 1'b0;
  int unsigned total_wr  = 0;
  int unsigned total_acc = 0;

  always @(posedge clk) begin
    if (write_enable[0]) mem0[write_address] <= write_data[0];
    if (write_enable[1]) mem1[write_address] <= write_data[1];
    if (corrupt_req) mem0[100] <= 8'h00;
    read_data[0] <= mem0[read_address];
    read_data[1] <= mem1[read_address];
    if (write_enable != 2'b00) total_wr <= total_wr + 1;
    if (in_valid && in_ready) total_acc <= total_acc + 1;
  end

  int cmp_n  = 0;
  int fail_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // pattern 0: {~k,k}; 1: all zero; 2: single marker word at k=37
  function automatic logic [15:0] word(input int pat, input int k);
    logic [7:0] kb;
    kb = k[7:0];
    case (pat)
      0:       return {~kb, kb};
      1:       return 16'h0000;
      default: return (k == 37) ? 16'h12C3 : 16'h0000;
    endcase
  endfunction

  typedef struct {
    int         pat;
    bit         toggle;
    bit         corrupt;
    int         exp_fill;
    bit         exp_pass;
    logic [7:0] exp_ck;
  } vec_t;

  task automatic feed(input int pat, input bit toggle, input int stop_at, output int fill);
    int k = 0;
    int i = 0;
    int first = -1;
    int last = -1;
    bit acc;
    bit ph = 1'b1;
    while (k < stop_at && i < 3000) begin
      @(negedge clk);
      in_data  = word(pat, k);
      in_valid = toggle ? ph : 1'b1;
      ph       = ~ph;
      acc      = in_valid && in_ready;
      @(posedge clk);
      if (acc) begin
        if (first < 0) first = i;
        last = i;
        k++;
      end
      i++;
    end
    check("feed_words", k, stop_at);
    fill = last - first + 1;
  endtask

  // Entered just after the final-accept edge; n counts edges until done is seen.
  task automatic wait_done(input bit clear_valid, input bit corrupt, output int n);
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (clear_valid) in_valid = 1'b0;
      corrupt_req = (n == 0) ? corrupt : 1'b0;
      if (n == 5) check("busy_mid_run", busy, 1);
      if (done) break;
      @(posedge clk);
      n++;
    end
    corrupt_req = 1'b0;
  endtask

  task automatic do_run(input vec_t v);
    int fill, n, bad;
    int unsigned wr0, acc0;
    logic [15:0] w;
    wr0  = total_wr;
    acc0 = total_acc;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("ready_after_start", in_ready, 1);
    check("pass_cleared", pass, 0);
    start = 1'b0;
    feed(v.pat, v.toggle, 512, fill);
    check("fill_cycles", fill, v.exp_fill);
    wait_done(1'b1, v.corrupt, n);
    check("done_latency", n, 514);
    check("pass", pass, v.exp_pass);
    check("checksum", checksum, v.exp_ck);
    check("idle_at_done", busy, 0);
    check("write_count", total_wr - wr0, 512);
    check("accept_count", total_acc - acc0, 512);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("pass_held", pass, v.exp_pass);
    if (!v.corrupt) begin
      bad = 0;
      for (int k = 0; k < 512; k++) begin
        w = word(v.pat, k);
        if (mem0[k] !== w[7:0] || mem1[k] !== w[15:8]) bad++;
      end
      check("ram_contents", bad, 0);
    end
  endtask

  vec_t tbl[5];

  initial begin
    int fill, n;
    int unsigned wr0, acc0;

    tbl[0] = '{0, 1'b0, 1'b0, 512,  1'b1, 8'h00};
    tbl[1] = '{0, 1'b1, 1'b0, 1023, 1'b1, 8'h00};
    tbl[2] = '{0, 1'b0, 1'b1, 512,  1'b0, 8'h00};
    tbl[3] = '{1, 1'b0, 1'b0, 512,  1'b1, 8'h00};
    tbl[4] = '{2, 1'b1, 1'b0, 1023, 1'b1, 8'hD1};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_waddr", write_address, 0);
    check("rst_wdata", write_data, 0);
    check("rst_we", write_enable, 0);
    check("rst_raddr", read_address, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_checksum", checksum, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ignores_valid", in_ready, 0);

    for (int r = 0; r < 5; r++) do_run(tbl[r]);

    // Reset in the middle of a load
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    feed(0, 1'b0, 300, fill);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", in_ready, 0);
    check("midrst_we", write_enable, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    check("midrst_ready_hold", in_ready, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    do_run(tbl[0]);

    // start held high and in_valid high outside the load phase
    wr0  = total_wr;
    acc0 = total_acc;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = word(0, 0);
    feed(0, 1'b0, 512, fill);
    check("held_fill", fill, 512);
    wait_done(1'b0, 1'b0, n);
    check("held_done_latency", n, 514);
    check("held_pass", pass, 1);
    check("held_accepts", total_acc - acc0, 512);
    check("held_writes", total_wr - wr0, 512);
    @(negedge clk);
    check("rerun_busy", busy, 1);
    check("rerun_ready", in_ready, 1);
    check("rerun_done_low", done, 0);
    start    = 1'b0;
    in_valid = 1'b0;
    feed(2, 1'b0, 512, fill);
    wait_done(1'b1, 1'b0, n);
    check("rerun_done_latency", n, 514);
    check("rerun_pass", pass, 1);
    check("rerun_checksum", checksum, 8'hD1);
    check("rerun_accepts", total_acc - acc0, 1024);
    check("rerun_writes", total_wr - wr0, 1024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
